// File: rtl/cvxif_mac4b_issuer.sv
// cvxif_mac4b_issuer
// -------------------------------------------------------------------------
// Core-side initiator for the CV-X-IF MAC4B offload. It takes operand-pair
// commands from a local stream and issues each one to the coprocessor. It
// then commits the instruction and collects the 4-lane MAC result. Results
// are summed over a burst that ends on a command flagged 'last'. The total
// is handed back together with an error code.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   cmd_valid_i/ready_o  command handshake (ready only in IDLE, out of reset)
//   cmd_rs1_i/rs2_i      packed 8-bit inputs / weights
//   cmd_rd_i, cmd_last_i destination tag, end-of-burst marker
//   cvxif_req_o          issue / commit / result-ready toward coprocessor
//   cvxif_resp_i         coprocessor response
//   acc_valid_o/ready_i  burst result handshake
//   acc_o, acc_cnt_o     accumulated sum and number of results
//   acc_err_o            00 ok, 01 rejected, 10 timeout, 11 bad result
// -------------------------------------------------------------------------

package cvxif_mac4b_pkg;

    localparam int X_ID_WIDTH = 4;
    localparam int X_NUM_RS   = 2;

    typedef struct packed {
        logic [15:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0]                   instr;
        logic [X_ID_WIDTH-1:0]         id;
        logic [X_NUM_RS-1:0][31:0]     rs;
        logic [X_NUM_RS-1:0]           rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic                  x_compressed_valid;
        x_compressed_req_t     x_compressed_req;
        logic                  x_issue_valid;
        x_issue_req_t          x_issue_req;
        logic                  x_commit_valid;
        x_commit_t             x_commit;
        logic                  x_mem_ready;
        x_mem_resp_t           x_mem_resp;
        logic                  x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           data;
        logic [4:0]            rd;
        logic                  we;
        logic                  exc;
    } x_result_t;

    typedef struct packed {
        logic          x_compressed_ready;
        logic          x_issue_ready;
        x_issue_resp_t x_issue_resp;
        logic          x_mem_valid;
        logic          x_result_valid;
        x_result_t     x_result;
    } cvxif_resp_t;

endpackage

module cvxif_mac4b_issuer
    import cvxif_mac4b_pkg::*;
#(
    parameter logic [31:0] MacInstr      = 32'h0000_007B,
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_rs1_i,
    input  logic [31:0] cmd_rs2_i,
    input  logic [4:0]  cmd_rd_i,
    input  logic        cmd_last_i,
    output cvxif_req_t  cvxif_req_o,
    input  cvxif_resp_t cvxif_resp_i,
    output logic        acc_valid_o,
    input  logic        acc_ready_i,
    output logic [31:0] acc_o,
    output logic [7:0]  acc_cnt_o,
    output logic [1:0]  acc_err_o
);

    localparam int unsigned TMO_W = $clog2(TimeoutCycles + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TimeoutCycles - 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_REJECT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_COMMIT = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e                state_r,  state_s;
    logic [31:0]           rs1_r,    rs1_s;
    logic [31:0]           rs2_r,    rs2_s;
    logic [4:0]            rd_r,     rd_s;
    logic                  last_r,   last_s;
    logic [X_ID_WIDTH-1:0] id_r,     id_s;
    logic [X_ID_WIDTH-1:0] iss_id_r, iss_id_s;
    logic [31:0]           acc_r,    acc_s;
    logic [7:0]            cnt_r,    cnt_s;
    logic [1:0]            err_r,    err_s;
    logic [TMO_W-1:0]      tmo_r,    tmo_s;
    logic                  result_ok_s;
    cvxif_req_t            req_s;

    // Response fields this initiator has no use for.
    logic unused_resp_s;
    assign unused_resp_s = ^{cvxif_resp_i.x_compressed_ready,
                             cvxif_resp_i.x_issue_resp.writeback,
                             cvxif_resp_i.x_issue_resp.exc,
                             cvxif_resp_i.x_mem_valid};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r  <= S_IDLE;
            rs1_r    <= 32'd0;
            rs2_r    <= 32'd0;
            rd_r     <= 5'd0;
            last_r   <= 1'b0;
            id_r     <= '0;
            iss_id_r <= '0;
            acc_r    <= 32'd0;
            cnt_r    <= 8'd0;
            err_r    <= ERR_OK;
            tmo_r    <= '0;
        end else begin
            state_r  <= state_s;
            rs1_r    <= rs1_s;
            rs2_r    <= rs2_s;
            rd_r     <= rd_s;
            last_r   <= last_s;
            id_r     <= id_s;
            iss_id_r <= iss_id_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            err_r    <= err_s;
            tmo_r    <= tmo_s;
        end
    end

    // A returned result is only accepted for the instruction we issued.
    always_comb begin
        result_ok_s = (cvxif_resp_i.x_result.id == iss_id_r) &&
                      (cvxif_resp_i.x_result.rd == rd_r) &&
                      cvxif_resp_i.x_result.we &&
                      !cvxif_resp_i.x_result.exc;
    end

    // Next-state and datapath update.
    always_comb begin
        state_s  = state_r;
        rs1_s    = rs1_r;
        rs2_s    = rs2_r;
        rd_s     = rd_r;
        last_s   = last_r;
        id_s     = id_r;
        iss_id_s = iss_id_r;
        acc_s    = acc_r;
        cnt_s    = cnt_r;
        err_s    = err_r;
        tmo_s    = tmo_r;

        case (state_r)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    rs1_s   = cmd_rs1_i;
                    rs2_s   = cmd_rs2_i;
                    rd_s    = cmd_rd_i;
                    last_s  = cmd_last_i;
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cvxif_resp_i.x_issue_ready) begin
                    if (cvxif_resp_i.x_issue_resp.accept) begin
                        iss_id_s = id_r;
                        id_s     = id_r + X_ID_WIDTH'(1);
                        tmo_s    = '0;
                        state_s  = S_COMMIT;
                    end else begin
                        err_s   = ERR_REJECT;
                        state_s = S_DONE;
                    end
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_COMMIT, S_WAIT: begin
                // A result in the final counted cycle still beats the timeout.
                if (cvxif_resp_i.x_result_valid) begin
                    if (result_ok_s) begin
                        acc_s   = acc_r + cvxif_resp_i.x_result.data;
                        cnt_s   = cnt_r + 8'd1;
                        state_s = last_r ? S_DONE : S_IDLE;
                    end else begin
                        err_s   = ERR_MISMATCH;
                        state_s = S_DONE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    err_s   = ERR_TIMEOUT;
                    state_s = S_DONE;
                end else begin
                    tmo_s   = tmo_r + TMO_W'(1);
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                if (acc_ready_i) begin
                    acc_s   = 32'd0;
                    cnt_s   = 8'd0;
                    err_s   = ERR_OK;
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Request decode from registered state; unused fields stay at zero.
    always_comb begin
        req_s = '0;
        case (state_r)
            S_ISSUE: begin
                req_s.x_issue_valid        = 1'b1;
                req_s.x_issue_req.instr    = {MacInstr[31:12], rd_r, MacInstr[6:0]};
                req_s.x_issue_req.id       = id_r;
                req_s.x_issue_req.rs[0]    = rs1_r;
                req_s.x_issue_req.rs[1]    = rs2_r;
                req_s.x_issue_req.rs_valid = {X_NUM_RS{1'b1}};
            end
            S_COMMIT: begin
                req_s.x_commit_valid          = 1'b1;
                req_s.x_commit.id             = iss_id_r;
                req_s.x_commit.commit_kill    = 1'b0;
                req_s.x_result_ready          = 1'b1;
            end
            S_WAIT: begin
                req_s.x_result_ready = 1'b1;
            end
            default: begin
                req_s = '0;
            end
        endcase
    end

    assign cvxif_req_o = req_s;
    assign cmd_ready_o = rst_ni && (state_r == S_IDLE);
    assign acc_valid_o = (state_r == S_DONE);
    assign acc_o       = acc_r;
    assign acc_cnt_o   = cnt_r;
    assign acc_err_o   = err_r;

endmodule

// File: tb/tb_cvxif_mac4b_issuer.sv
// Directed bench for cvxif_mac4b_issuer. A small behavioural coprocessor
// answers issues one cycle after the handshake; its behaviour (normal,
// reject, drop, bad id, exception) is selected per test.
module tb_cvxif_mac4b_issuer;
    import cvxif_mac4b_pkg::*;

    localparam int TMO = 4;

    localparam int M_OK     = 0;
    localparam int M_REJECT = 1;
    localparam int M_DROP   = 2;
    localparam int M_BADID  = 3;
    localparam int M_EXC    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic [4:0]  cmd_rd;
    logic        cmd_last;
    cvxif_req_t  req;
    cvxif_resp_t resp;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc;
    logic [7:0]  acc_cnt;
    logic [1:0]  acc_err;

    int          mode;
    logic        co_issue_ready;
    logic        res_valid_r = 1'b0;
    x_result_t   res_r       = '0;
    logic        inj_valid;
    x_result_t   inj_res;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;
    int prev_cyc;

    cvxif_mac4b_issuer #(
        .MacInstr      (32'h0000_007B),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_rs1_i    (cmd_rs1),
        .cmd_rs2_i    (cmd_rs2),
        .cmd_rd_i     (cmd_rd),
        .cmd_last_i   (cmd_last),
        .cvxif_req_o  (req),
        .cvxif_resp_i (resp),
        .acc_valid_o  (acc_valid),
        .acc_ready_i  (acc_ready),
        .acc_o        (acc),
        .acc_cnt_o    (acc_cnt),
        .acc_err_o    (acc_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        int p;
        s = 32'd0;
        for (int i = 0; i < 4; i++) begin
            p = int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
            s = s + 32'(p);
        end
        return s;
    endfunction

    // Coprocessor model: registered result one cycle after an accepted issue.
    always @(posedge clk) begin
        res_valid_r <= 1'b0;
        if (req.x_issue_valid && co_issue_ready && mode != M_REJECT && mode != M_DROP) begin
            res_valid_r <= 1'b1;
            res_r.id    <= (mode == M_BADID) ? req.x_issue_req.id + 4'd1 : req.x_issue_req.id;
            res_r.data  <= dot4(req.x_issue_req.rs[0], req.x_issue_req.rs[1]);
            res_r.rd    <= req.x_issue_req.instr[11:7];
            res_r.we    <= 1'b1;
            res_r.exc   <= (mode == M_EXC);
        end
    end

    always_comb begin
        resp = '0;
        resp.x_issue_ready       = co_issue_ready;
        resp.x_issue_resp.accept = (mode != M_REJECT);
        resp.x_result_valid      = res_valid_r | inj_valid;
        resp.x_result            = inj_valid ? inj_res : res_r;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Returns in the cycle after acceptance (first ISSUE cycle).
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rs1   = a;
        cmd_rs2   = b;
        cmd_rd    = rd;
        cmd_last  = last;
        while (!cmd_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!acc_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_valid", {31'd0, acc_valid}, 32'd1);
    endtask

    task automatic consume();
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        check_eq("consume_valid", {31'd0, acc_valid}, 32'd0);
        check_eq("consume_acc", acc, 32'd0);
        check_eq("consume_err", {30'd0, acc_err}, 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        check_eq({tag, "_req_zero"}, {31'd0, |req}, 32'd0);
        check_eq({tag, "_acc_valid"}, {31'd0, acc_valid}, 32'd0);
        check_eq({tag, "_acc"}, acc, 32'd0);
        check_eq({tag, "_cnt"}, {24'd0, acc_cnt}, 32'd0);
        check_eq({tag, "_err"}, {30'd0, acc_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_zero("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_rs1        = 32'd0;
        cmd_rs2        = 32'd0;
        cmd_rd         = 5'd0;
        cmd_last       = 1'b0;
        acc_ready      = 1'b0;
        mode           = M_OK;
        co_issue_ready = 1'b1;
        inj_valid      = 1'b0;
        inj_res        = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Single-command burst: 1+2+3+4 = 10
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd1, 1'b1);
        check_eq("t1_issue_valid", {31'd0, req.x_issue_valid}, 32'd1);
        check_eq("t1_issue_id", {28'd0, req.x_issue_req.id}, 32'd0);
        check_eq("t1_instr", req.x_issue_req.instr, 32'h0000_00FB);
        check_eq("t1_rs0", req.x_issue_req.rs[0], 32'h0403_0201);
        check_eq("t1_rs1", req.x_issue_req.rs[1], 32'h0101_0101);
        check_eq("t1_rs_valid", {30'd0, req.x_issue_req.rs_valid}, 32'd3);
        @(negedge clk);
        check_eq("t1_commit_valid", {31'd0, req.x_commit_valid}, 32'd1);
        check_eq("t1_commit_id", {28'd0, req.x_commit.id}, 32'd0);
        check_eq("t1_commit_kill", {31'd0, req.x_commit.commit_kill}, 32'd0);
        check_eq("t1_result_ready", {31'd0, req.x_result_ready}, 32'd1);
        check_eq("t1_issue_low", {31'd0, req.x_issue_valid}, 32'd0);
        @(negedge clk);
        check_eq("t1_commit_once", {31'd0, req.x_commit_valid}, 32'd0);
        check_eq("t1_acc_valid", {31'd0, acc_valid}, 32'd1);
        check_eq("t1_acc", acc, 32'd10);
        check_eq("t1_cnt", {24'd0, acc_cnt}, 32'd1);
        check_eq("t1_err", {30'd0, acc_err}, 32'd0);
        consume();

        // Four-command burst: 4 * 0xFC04 = 0x3F010, ids 0..3, 3 cycles each
        do_reset();
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(32'h7F7F_7F7F, 32'h7F7F_7F7F, 5'd3, (i == 3));
            check_eq("t2_issue_id", {28'd0, req.x_issue_req.id}, 32'(i));
            if (i > 0) check_eq("t2_period", 32'(acc_cyc - prev_cyc), 32'd3);
            prev_cyc = acc_cyc;
        end
        wait_done();
        check_eq("t2_acc", acc, 32'h0003_F010);
        check_eq("t2_cnt", {24'd0, acc_cnt}, 32'd4);
        check_eq("t2_err", {30'd0, acc_err}, 32'd0);
        consume();

        // Issue backpressure for 5 cycles (longer than the timeout)
        co_issue_ready = 1'b0;
        send_cmd(32'h0102_0304, 32'h0202_0202, 5'd7, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_hold_valid", {31'd0, req.x_issue_valid}, 32'd1);
            check_eq("t3_hold_instr", req.x_issue_req.instr, 32'h0000_03FB);
            check_eq("t3_hold_rs0", req.x_issue_req.rs[0], 32'h0102_0304);
            check_eq("t3_hold_id", {28'd0, req.x_issue_req.id}, 32'd4);
            check_eq("t3_no_commit", {31'd0, req.x_commit_valid}, 32'd0);
            @(negedge clk);
        end
        co_issue_ready = 1'b1;
        wait_done();
        check_eq("t3_acc", acc, 32'd20);
        check_eq("t3_err", {30'd0, acc_err}, 32'd0);
        consume();

        // Rejection: DONE with err=01 and no commit
        mode = M_REJECT;
        send_cmd(32'h1111_1111, 32'h2222_2222, 5'd5, 1'b0);
        @(negedge clk);
        check_eq("t4_no_commit", {31'd0, req.x_commit_valid}, 32'd0);
        check_eq("t4_acc_valid", {31'd0, acc_valid}, 32'd1);
        check_eq("t4_err", {30'd0, acc_err}, 32'd1);
        check_eq("t4_cnt", {24'd0, acc_cnt}, 32'd0);
        consume();

        // Timeout: DONE exactly TMO cycles after entering COMMIT
        mode = M_DROP;
        send_cmd(32'h0101_0101, 32'h0101_0101, 5'd6, 1'b1);
        @(negedge clk);
        for (int k = 0; k < TMO; k++) begin
            check_eq("t5_waiting", {31'd0, acc_valid}, 32'd0);
            check_eq("t5_rready", {31'd0, req.x_result_ready}, 32'd1);
            @(negedge clk);
        end
        check_eq("t5_acc_valid", {31'd0, acc_valid}, 32'd1);
        check_eq("t5_err", {30'd0, acc_err}, 32'd2);
        check_eq("t5_cnt", {24'd0, acc_cnt}, 32'd0);
        consume();

        // Result in the very cycle the counter reaches the limit wins
        send_cmd(32'h0101_0101, 32'h0101_0101, 5'd9, 1'b1);
        check_eq("t6_issue_id", {28'd0, req.x_issue_req.id}, 32'd6);
        for (int k = 0; k < TMO; k++) @(negedge clk);
        inj_res   = '{id: 4'd6, data: 32'h1234_5678, rd: 5'd9, we: 1'b1, exc: 1'b0};
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        check_eq("t6_acc_valid", {31'd0, acc_valid}, 32'd1);
        check_eq("t6_err", {30'd0, acc_err}, 32'd0);
        check_eq("t6_acc", acc, 32'h1234_5678);
        check_eq("t6_cnt", {24'd0, acc_cnt}, 32'd1);
        consume();

        // Wrong id on the second result: err=11, acc keeps first result
        mode = M_OK;
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd2, 1'b0);
        @(negedge clk);
        mode = M_BADID;
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd2, 1'b1);
        wait_done();
        check_eq("t7_err", {30'd0, acc_err}, 32'd3);
        check_eq("t7_acc", acc, 32'd10);
        check_eq("t7_cnt", {24'd0, acc_cnt}, 32'd1);
        consume();

        // Exception flag on the result: err=11
        mode = M_EXC;
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd2, 1'b1);
        wait_done();
        check_eq("t8_err", {30'd0, acc_err}, 32'd3);
        check_eq("t8_acc", acc, 32'd0);
        check_eq("t8_cnt", {24'd0, acc_cnt}, 32'd0);
        consume();

        // Reset while waiting for a result
        mode = M_DROP;
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd4, 1'b1);
        check_eq("t9_issue_id", {28'd0, req.x_issue_req.id}, 32'd10);
        @(negedge clk);
        @(negedge clk);
        check_eq("t9_in_wait", {31'd0, req.x_result_ready}, 32'd1);
        check_eq("t9_wait_no_commit", {31'd0, req.x_commit_valid}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_zero("t9_rst");
        rst_n     = 1'b1;
        inj_res   = '{id: 4'd10, data: 32'h0000_0055, rd: 5'd4, we: 1'b1, exc: 1'b0};
        inj_valid = 1'b1;
        check_eq("t9_stray_rready", {31'd0, req.x_result_ready}, 32'd0);
        @(negedge clk);
        inj_valid = 1'b0;
        check_eq("t9_stray_valid", {31'd0, acc_valid}, 32'd0);
        check_eq("t9_stray_acc", acc, 32'd0);
        check_eq("t9_stray_cnt", {24'd0, acc_cnt}, 32'd0);
        check_eq("t9_idle_ready", {31'd0, cmd_ready}, 32'd1);
        mode = M_OK;
        send_cmd(32'h0403_0201, 32'h0101_0101, 5'd1, 1'b1);
        check_eq("t9_id_restart", {28'd0, req.x_issue_req.id}, 32'd0);
        wait_done();
        check_eq("t9_acc", acc, 32'd10);
        check_eq("t9_cnt", {24'd0, acc_cnt}, 32'd1);
        check_eq("t9_err", {30'd0, acc_err}, 32'd0);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cvxif_mac4b_issuer.md
# cvxif_mac4b_issuer

Core-side initiator for the CV-X-IF MAC4B offload. It takes operand-pair commands from a local stream and drives the issue, commit and result channels toward `cvxif_mac4b_coprocessor`. It accumulates the returned 4-lane MAC sums over a burst and hands the total back with an error code. It stands in for the CVA6 issue stage in block-level tests, and serves as a DMA-style MAC sequencer in the subsystem.

## Interface
- `MacInstr`, default `32'h0000_007B`: instruction template; bits [11:7] are replaced by `cmd_rd_i`.
- `TimeoutCycles`, default 16: maximum cycles spent in COMMIT+WAIT before a timeout is declared (≥2).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_rs1_i`  in  32  four packed 8-bit inputs.
- `cmd_rs2_i`  in  32  four packed 8-bit weights.
- `cmd_rd_i`  in  5  destination register tag.
- `cmd_last_i`  in  1  last command of a burst.
- `cvxif_req_o`  out  `cvxif_req_t`  issue/commit/result-ready toward the coprocessor. Compressed and mem fields are tied to 0.
- `cvxif_resp_i`  in  `cvxif_resp_t`  coprocessor response.
- `acc_valid_o`  out  1  burst result valid.
- `acc_ready_i`  in  1  burst result consumed.
- `acc_o`  out  32  accumulated sum.
- `acc_cnt_o`  out  8  number of results accumulated in the burst.
- `acc_err_o`  out  2  error code: 00 ok, 01 rejected, 10 timeout, 11 result mismatch/exception.

## Operation
- FSM states: IDLE, ISSUE, COMMIT, WAIT, DONE. Reset state is IDLE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: latch rs1, rs2, rd and last into operand registers, then go to ISSUE.
- **ISSUE**
  - Drive `x_issue_valid`=1, `instr`=`MacInstr` with [11:7]=rd, `rs[0]`=rs1, `rs[1]`=rs2, `rs_valid`=all ones, `id`=id_q.
  - Hold until `x_issue_ready`.
  - On handshake with `accept`=1: id_q increments (wraps modulo 2^X_ID_WIDTH), go to COMMIT.
  - On handshake with `accept`=0: set err=01 and go to DONE.
- **COMMIT**
  - Drive `x_commit_valid`=1 for exactly one cycle, with `commit.id` = issued id and `commit_kill`=0.
  - Then go to WAIT, unless the result was already taken in this cycle.
- **COMMIT and WAIT (result collection)**
  - `x_result_ready`=1.
  - On `x_result_valid`: check that `id` matches the issued id, `rd` matches, `we`=1 and `exc`=0.
  - Check fails: set err=11 and go to DONE.
  - Check passes: acc += `data`, acc_cnt += 1. Next state is DONE if last=1, otherwise IDLE.
  - A result arriving in the COMMIT cycle is legal: the commit pulse is still emitted, and the FSM leaves directly to IDLE/DONE.
- **Timeout**
  - A counter starts at 0 on entering COMMIT and increments every cycle in COMMIT/WAIT.
  - Reaching `TimeoutCycles` without a result: set err=10 and go to DONE.
  - A result arriving in the same cycle the counter hits the limit wins: no timeout.
- **DONE**
  - `acc_valid_o`=1; `acc_o`, `acc_cnt_o` and `acc_err_o` are held stable.
  - On `acc_ready_i`: clear acc, acc_cnt and err, then return to IDLE.
- **Arithmetic**
  - acc is 32-bit with wrap-around on overflow.
  - acc_cnt is 8-bit and wraps.
  - An error aborts the burst; later commands start a new burst.
- `cvxif_req_o` fields not driven by the current state are 0.
- **Reset**
  - While `rst_ni`=0 at a clock edge: state=IDLE, acc=0, acc_cnt=0, err=0, id_q=0, timeout counter=0.
  - All outputs are 0 while in reset, including `cmd_ready_o`, which is gated by `rst_ni`.
  - Reset mid-burst discards all state. A late result after reset is ignored, because `x_result_ready` is 0 and the FSM is in IDLE.

## Timing
- Command accepted at edge N; `x_issue_valid` is high in cycle N+1.
- With `x_issue_ready`=1, the issue handshake occurs in N+1, `x_commit_valid` pulses in N+2, and `x_result_ready` is high from N+2.
- Against the one-cycle-registered coprocessor, the result arrives in N+2. This gives an IDLE→IDLE throughput of 3 cycles per command.
- `acc_valid_o` rises one cycle after the last result.
- Issue payload is stable while `x_issue_valid`=1 and not ready.
- `cmd_ready_o` is combinational from state: 1 only in IDLE, and gated by `rst_ni`.
- All other outputs are functions of registered state only.

## Test plan
- **Single-command burst:** rs1=0x04030201, rs2=0x01010101, last=1 → one issue with id=0, a commit pulse, then `acc_valid_o` with acc=10, cnt=1, err=00.
- **Four-command burst:**
  - Stimulus: each command with rs1=0x7F7F7F7F, rs2=0x7F7F7F7F.
  - Each result is 0x0000FC04, so acc=0x0003F010 and cnt=4.
  - Ids are 0,1,2,3, and each command takes 3 cycles.
- **Backpressure on issue:** hold `x_issue_ready`=0 for 5 cycles → issue payload stable, no commit, no timeout counting; completes normally afterwards.
- **Rejection and timeout:**
  - Force `accept`=0 → DONE with err=01, cnt=0, no commit pulse.
  - Separately, suppress the result → DONE with err=10 exactly `TimeoutCycles` cycles after entering COMMIT.
- **Result mismatch:** inject a result with the wrong id, or with exc=1 → err=11, acc unchanged.
- **Reset mid-operation:**
  - Assert `rst_ni`=0 for one edge while in WAIT → all outputs 0 and id_q=0.
  - A stray result is ignored, and the next command issues with id=0.
